// File: rtl/door_pkg.sv
// Shared types for the timed door controller.
// State codes are fixed because they appear on the external state port.
package door_pkg;

    localparam int DOOR_STATE_W = 3;

    typedef enum logic [DOOR_STATE_W-1:0] {
        CLOSED    = 3'd0,
        OPENING   = 3'd1,
        OPEN_HOLD = 3'd2,
        CLOSING   = 3'd3,
        STOPPED   = 3'd4,
        FAULT     = 3'd5
    } door_state_t;

    // Bit positions of the asynchronous inputs inside the synchroniser vector.
    localparam int IN_SENSOR    = 0;
    localparam int IN_ESTOP     = 1;
    localparam int IN_LIMIT_OPN = 2;
    localparam int IN_LIMIT_CLS = 3;
    localparam int IN_FAULT_CLR = 4;
    localparam int IN_W         = 5;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs, W bits wide.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_d, meta_q;
    logic [W-1:0] sync_d, sync_q;

    // Shift the raw input through two stages; only the second stage is used.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchroniser stages, cleared by reset so the FSM starts with all inputs low.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/door_ctrl_timed.sv
// Automatic door controller with hold-open timer, reversal, e-stop recovery
// and a sticky fault state. Define DOOR_TRAVEL_TIMEOUT_EN to fault when a
// single opening or closing travel lasts TRAVEL_CYCLES cycles.
module door_ctrl_timed
    import door_pkg::*;
#(
    parameter int TIMER_W       = 16,
    parameter int HOLD_CYCLES   = 1000,
    parameter int TRAVEL_CYCLES = 5000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    sensor,
    input  logic                    estop,
    input  logic                    limit_open,
    input  logic                    limit_closed,
    input  logic                    fault_clr,
    output logic                    motor_open,
    output logic                    motor_close,
    output logic [DOOR_STATE_W-1:0] state,
    output logic                    fault
);

    // Reject illegal timer settings at elaboration.
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2 ** TIMER_W) - 1 ||
        TRAVEL_CYCLES < 1 || TRAVEL_CYCLES > (2 ** TIMER_W) - 1) begin : g_bad_param
        $error("door_ctrl_timed: HOLD_CYCLES/TRAVEL_CYCLES out of range for TIMER_W");
    end

    localparam logic [TIMER_W-1:0] HOLD_VAL = TIMER_W'(HOLD_CYCLES);
`ifdef DOOR_TRAVEL_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] TRAVEL_VAL = TIMER_W'(TRAVEL_CYCLES);
`endif

    logic [IN_W-1:0] in_raw, in_sync;
    logic            sensor_s, estop_s, lim_open_s, lim_closed_s, fault_clr_s;

    door_state_t        state_d, state_q;
    logic [TIMER_W-1:0] cnt_d, cnt_q;
    logic [TIMER_W-1:0] cnt_inc;
    logic               travel_timeout;

    assign in_raw = {fault_clr, limit_closed, limit_open, estop, sensor};

    sync2 #(.W(IN_W)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (in_raw),
        .q     (in_sync)
    );

    assign sensor_s     = in_sync[IN_SENSOR];
    assign estop_s      = in_sync[IN_ESTOP];
    assign lim_open_s   = in_sync[IN_LIMIT_OPN];
    assign lim_closed_s = in_sync[IN_LIMIT_CLS];
    assign fault_clr_s  = in_sync[IN_FAULT_CLR];

    // Saturating increment and, when enabled, the travel-timeout compare.
    // The fault lands on the edge where the counter would reach TRAVEL_CYCLES,
    // so the motor is driven for exactly TRAVEL_CYCLES cycles.
    always_comb begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
`ifdef DOOR_TRAVEL_TIMEOUT_EN
        travel_timeout = (cnt_inc == TRAVEL_VAL);
`else
        travel_timeout = 1'b0;
`endif
    end

    // Next state and counter: illegal code, estop, limit conflict, then per-state rules.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ena) begin
            if (state_q == OPENING || state_q == CLOSING) begin
                cnt_d = cnt_inc;
            end
            if (state_q > FAULT) begin
                state_d = FAULT;
            end else if (estop_s && state_q != FAULT) begin
                state_d = STOPPED;
            end else if (lim_open_s && lim_closed_s) begin
                state_d = FAULT;
            end else begin
                case (state_q)
                    CLOSED: begin
                        if (sensor_s) state_d = OPENING;
                    end
                    OPENING: begin
                        if (lim_open_s) begin
                            state_d = OPEN_HOLD;
                            cnt_d   = HOLD_VAL;
                        end else if (travel_timeout) begin
                            state_d = FAULT;
                        end
                    end
                    OPEN_HOLD: begin
                        if (sensor_s) begin
                            cnt_d = HOLD_VAL;
                        end else if (cnt_q <= TIMER_W'(1)) begin
                            state_d = CLOSING;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    CLOSING: begin
                        if (sensor_s)            state_d = OPENING;
                        else if (lim_closed_s)   state_d = CLOSED;
                        else if (travel_timeout) state_d = FAULT;
                    end
                    STOPPED: begin
                        // estop is known low here; a stop always recovers towards open.
                        if (lim_open_s) begin
                            state_d = OPEN_HOLD;
                            cnt_d   = HOLD_VAL;
                        end else begin
                            state_d = OPENING;
                        end
                    end
                    FAULT: begin
                        if (fault_clr_s && !estop_s) state_d = STOPPED;
                    end
                    default: state_d = FAULT;
                endcase
            end
            // Every fresh travel starts timing from zero.
            if (state_d != state_q && (state_d == OPENING || state_d == CLOSING)) begin
                cnt_d = '0;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLOSED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode straight from state so reset drops the motors without a clock.
    always_comb begin
        motor_open  = ena && (state_q == OPENING);
        motor_close = ena && (state_q == CLOSING);
        fault       = (state_q == FAULT);
        state       = state_q;
    end

endmodule

// File: tb/tb_door_ctrl_timed.sv
// Directed bench for door_ctrl_timed with HOLD_CYCLES=8, TRAVEL_CYCLES=20.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_door_ctrl_timed;

    logic       clk, rst_n, ena;
    logic       sensor, estop, limit_open, limit_closed, fault_clr;
    logic       motor_open, motor_close, fault;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    door_ctrl_timed #(
        .TIMER_W       (16),
        .HOLD_CYCLES   (8),
        .TRAVEL_CYCLES (20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .sensor       (sensor),
        .estop        (estop),
        .limit_open   (limit_open),
        .limit_closed (limit_closed),
        .fault_clr    (fault_clr),
        .motor_open   (motor_open),
        .motor_close  (motor_close),
        .state        (state),
        .fault        (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1;
        sensor = 1'b0; estop = 1'b0; limit_open = 1'b0; limit_closed = 1'b0; fault_clr = 1'b0;
        #1;
        check("rst_state", state, 0);
        check("rst_motor_open", motor_open, 0);
        check("rst_motor_close", motor_close, 0);
        check("rst_fault", fault, 0);
        check("rst_cnt", dut.cnt_q, 0);
        step(2);
        rst_n = 1'b1;
        step(2);
        check("idle_state", state, 0);

        // Basic cycle: 2-cycle sensor pulse, open, hold, close.
        sensor = 1'b1;
        step(2);
        sensor = 1'b0;
        check("latency_2_edges", state, 0);
        step(1);
        check("open_state", state, 1);
        check("open_motor", motor_open, 1);
        check("open_no_close", motor_close, 0);
        limit_open = 1'b1;
        step(3);
        check("hold_state", state, 2);
        check("hold_cnt_load", dut.cnt_q, 8);
        step(7);
        check("hold_last_cycle", state, 2);
        step(1);
        check("closing_state", state, 3);
        check("closing_motor", motor_close, 1);
        check("closing_no_open", motor_open, 0);
        limit_open = 1'b0;
        step(3);
        limit_closed = 1'b1;
        step(2);
        check("closed_latency", state, 3);
        step(1);
        check("closed_state", state, 0);
        check("closed_motors", {motor_open, motor_close}, 0);

        // Hold retrigger at counter=3.
        sensor = 1'b1; limit_closed = 1'b0;
        step(3);
        check("rt_opening", state, 1);
        sensor = 1'b0; limit_open = 1'b1;
        step(3);
        check("rt_hold", state, 2);
        step(3);
        sensor = 1'b1;
        step(1);
        sensor = 1'b0;
        step(1);
        check("rt_cnt3", dut.cnt_q, 3);
        step(1);
        check("rt_reload", dut.cnt_q, 8);
        step(7);
        check("rt_still_hold", state, 2);
        step(1);
        check("rt_closing", state, 3);

        // Reversal: sensor and limit_closed together while closing.
        sensor = 1'b1; limit_closed = 1'b1; limit_open = 1'b0;
        step(3);
        check("rev_state", state, 1);
        check("rev_motor_open", motor_open, 1);
        check("rev_motor_close", motor_close, 0);
        sensor = 1'b0; limit_closed = 1'b0; limit_open = 1'b1;
        step(3);
        check("rev_hold", state, 2);
        check("rev_hold_cnt", dut.cnt_q, 8);

        // Emergency stop during closing and both recovery paths.
        step(8);
        check("es_closing", state, 3);
        limit_open = 1'b0; estop = 1'b1;
        step(3);
        check("es_stopped", state, 4);
        check("es_motors", {motor_open, motor_close}, 0);
        estop = 1'b0;
        step(3);
        check("es_resume_open", state, 1);
        estop = 1'b1;
        step(3);
        check("es_stopped2", state, 4);
        estop = 1'b0; limit_open = 1'b1;
        step(3);
        check("es_resume_hold", state, 2);

        // Limit conflict fault and clearing.
        limit_closed = 1'b1;
        step(3);
        check("flt_state", state, 5);
        check("flt_flag", fault, 1);
        check("flt_motors", {motor_open, motor_close}, 0);
        fault_clr = 1'b1;
        step(3);
        check("flt_clr_conflict", state, 5);
        limit_closed = 1'b0;
        step(3);
        check("flt_cleared", state, 4);
        check("flt_flag_low", fault, 0);
        fault_clr = 1'b0;

        // Into OPENING again, then ena freeze.
        limit_open = 1'b0; estop = 1'b1;
        step(3);
        check("ena_pre_stop", state, 4);
        estop = 1'b0;
        step(3);
        check("ena_opening", state, 1);
        check("ena_cnt_clear", dut.cnt_q, 0);
        step(4);
        check("ena_cnt4", dut.cnt_q, 4);
        ena = 1'b0;
        step(10);
        check("ena_motor_off", motor_open, 0);
        check("ena_state_held", state, 1);
        check("ena_cnt_held", dut.cnt_q, 4);
        ena = 1'b1;
        #1;
        check("ena_motor_back", motor_open, 1);
        step(1);
        check("ena_cnt_resume", dut.cnt_q, 5);

        // Travel timeout boundary.
        step(14);
        check("to_before", state, 1);
        check("to_cnt19", dut.cnt_q, 19);
        step(1);
`ifdef DOOR_TRAVEL_TIMEOUT_EN
        check("to_fault", state, 5);
        fault_clr = 1'b1;
        step(4);
        fault_clr = 1'b0;
        check("to_reopen", state, 1);
`else
        check("to_no_fault", state, 1);
        check("to_cnt20", dut.cnt_q, 20);
`endif

        // Asynchronous reset mid-travel, checked before any further edge.
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_motor_open", motor_open, 0);
        check("arst_state", state, 0);
        check("arst_cnt", dut.cnt_q, 0);
        #2;
        rst_n = 1'b1;
        step(1);
        check("arst_idle", state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/door_ctrl_timed.md
# door_ctrl_timed

Parametrised automatic-door controller: the next-generation door FSM for the Tiny Tapeout top level. It drives open/close motor enables from a presence sensor, an emergency stop and two limit switches. Over the previous one-hot-transition door FSM it adds:

- input synchronisation
- a programmable hold-open timer
- reversal on presence while closing
- emergency-stop recovery
- a sticky fault state for inconsistent limits and, optionally, travel timeout

## Interface
Parameters:
- TIMER_W, 16, width of the shared cycle counter.
- HOLD_CYCLES, 1000, cycles the door stays open after presence clears. Legal range 1 .. 2^TIMER_W-1.
- TRAVEL_CYCLES, 5000, maximum cycles in OPENING or CLOSING before a timeout fault. Legal range 1 .. 2^TIMER_W-1.

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  global enable. Low freezes state and counter and forces both motor outputs to 0.
- sensor  in  1  presence sensor, active high, asynchronous.
- estop  in  1  emergency stop, active high, asynchronous.
- limit_open  in  1  fully-open limit switch, asynchronous.
- limit_closed  in  1  fully-closed limit switch, asynchronous.
- fault_clr  in  1  fault acknowledge, level, asynchronous.
- motor_open  out  1  open-motor enable.
- motor_close  out  1  close-motor enable.
- state  out  3  current state code.
- fault  out  1  high in FAULT.

## Operation
- All five asynchronous inputs pass through 2-flop synchronisers. The FSM sees only the synchronised versions.
- State codes: CLOSED=0, OPENING=1, OPEN_HOLD=2, CLOSING=3, STOPPED=4, FAULT=5. Codes 6 and 7 are illegal and go to FAULT.
- Transition priority, evaluated each enabled cycle:
  1. estop → STOPPED, from any state except FAULT.
  2. limit_open and limit_closed both high → FAULT.
  3. The per-state rules below.
- Per-state rules:
  - CLOSED: sensor → OPENING.
  - OPENING: limit_open → OPEN_HOLD, loading counter = HOLD_CYCLES.
  - OPEN_HOLD: sensor reloads counter = HOLD_CYCLES. Otherwise the counter decrements. When the counter is 1 and sensor is low → CLOSING.
  - CLOSING: sensor → OPENING (reversal; takes precedence over limit_closed). Otherwise limit_closed → CLOSED.
  - STOPPED: motors off. When estop is low: limit_open → OPEN_HOLD (counter = HOLD_CYCLES), else → OPENING. A stop never resumes closing.
  - FAULT: motors off. Stays in FAULT while estop is high. fault_clr high with limits consistent → STOPPED.
- Counter reset rules:
  - Entering OPENING or CLOSING clears the counter.
  - The counter increments while in OPENING or CLOSING and saturates at all-ones.
- Outputs:
  - motor_open = (state==OPENING) & ena.
  - motor_close = (state==CLOSING) & ena.
  - Both motors are never high together.
- ena low: no transitions, counter holds, synchronisers keep sampling.

## Timing
- Reset values:
  - state = CLOSED
  - counter = 0
  - synchroniser flops = 0
  - motor_open = 0, motor_close = 0, fault = 0
- Reset asserted mid-travel: motors drop immediately, with no clock required.
- Latency from an input pin edge to a state change: 3 clk edges (2 synchroniser edges + 1 state register edge). Motor outputs follow state combinationally.
- Hold-open time: exactly HOLD_CYCLES enabled cycles in OPEN_HOLD after the last cycle with synchronised sensor high.
- Travel timeout fires on the cycle the counter equals TRAVEL_CYCLES while still travelling, giving TRAVEL_CYCLES cycles of motor drive.
- Simultaneous events:
  - estop beats everything.
  - A limit conflict beats the state rules.
  - In CLOSING, sensor beats limit_closed.

## Configuration
- Macro: DOOR_TRAVEL_TIMEOUT_EN.
- Defined: OPENING or CLOSING with counter == TRAVEL_CYCLES → FAULT.
- Undefined: no timeout comparator. The counter is still used for hold-open. FAULT is reachable only via limit conflict or an illegal state code, and TRAVEL_CYCLES is ignored.

## Structure
- Shared package door_pkg:
  - state enum door_state_t with the codes above
  - DOOR_STATE_W = 3
- Sub-module sync2: a 2-flop synchroniser with async active-low reset. Instantiated once per input, or once as a 5-bit vector.
- FSM, counter and output decode live in door_ctrl_timed.

## Test plan
All scenarios use HOLD_CYCLES=8 and TRAVEL_CYCLES=20.

- Reset, then sensor pulse for 2 cycles → state=1 and motor_open=1 three edges after the pulse; limit_open high → state=2; 8 cycles after sync'd sensor low → state=3, motor_close=1; limit_closed → state=0, motors 0.
- Hold retrigger: in OPEN_HOLD, pulse sensor at counter=3 → counter reloads to 8; CLOSING is entered 8 cycles after the pulse clears.
- Reversal: in CLOSING, assert sensor and limit_closed on the same cycle → state=1, motor_open=1, motor_close=0.
- Emergency stop: estop during CLOSING → state=4, motors 0; release with limit_open=0 → state=1; release with limit_open=1 → state=2.
- Faults:
  - Both limits high → state=5, fault=1.
  - fault_clr held while limits are still both high → remains 5.
  - Limits fixed, then fault_clr → state=4.
  - With DOOR_TRAVEL_TIMEOUT_EN: OPENING for 20 cycles without limit_open → state=5.
  - Without the macro: remains in state 1.
- ena low mid-OPENING for 10 cycles → motor_open=0 and state and counter held; ena high → resumes OPENING with counter unchanged. Async reset during OPENING → motors 0 immediately.
